alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, meaning: PC value loaded at reset and on each start.
REQ-002 Ports (name  direction  width  meaning):
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin execution from RESET_PC; honoured only in IDLE or HALT.
- mem_req  output  1  memory request, held high until acknowledged.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  output  8  memory byte address.
- mem_wdata  output  8  write data (AC).
- mem_rdata  input  8  read data, valid when mem_ack is high.
- mem_ack  input  1  one-cycle completion of the current request.
- alu_mode  output  3  ALU operation select.
- alu_activate  output  1  one-cycle ALU strobe.
- alu_result  input  8  ALU output, valid the cycle after alu_activate.
- ac  output  8  accumulator.
- pc  output  8  program counter.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high in HALT.

Function
REQ-003 Instructions are two bytes: opcode at PC, operand address at PC+1; opcode[2:0] = mode, opcode[7:3] ignored.
REQ-004 Modes: 000 add, 001 shl, 010 xnor, 011 shr, 100 load, 101 store, 110 negate, 111 halt.
REQ-005 States: IDLE, FETCH_OP, FETCH_ADR, READ_DR, EXEC, WB, STORE, HALT.
REQ-006 IDLE/HALT -> FETCH_OP on start=1; PC <= RESET_PC.
REQ-007 FETCH_OP: read at PC; on mem_ack, IR <= mem_rdata and PC <= PC+1.
- Mode 111 -> HALT.
- Any other mode -> FETCH_ADR.
REQ-008 FETCH_ADR: read at PC; on mem_ack, OPA <= mem_rdata and PC <= PC+1.
- Mode 101 -> STORE.
- Mode 110 -> EXEC.
- Any other mode -> READ_DR.
REQ-009 READ_DR: read at OPA; on mem_ack, DR <= mem_rdata; -> EXEC.
REQ-010 EXEC lasts one cycle: alu_mode = IR[2:0], alu_activate = 1; -> WB.
REQ-011 WB lasts one cycle: AC <= alu_result; -> FETCH_OP.
REQ-012 STORE: write AC to OPA (mem_we = 1, mem_wdata = ac); on mem_ack -> FETCH_OP; AC unchanged.
REQ-013 Handshake:
- mem_req rises on entry to a memory state.
- mem_addr, mem_we and mem_wdata stay constant while mem_req = 1.
- mem_req falls in the cycle after mem_ack is sampled.
- Wait cycles are unbounded.
- mem_ack while mem_req = 0 is ignored.
REQ-014 alu_activate = 0 outside EXEC; alu_mode holds IR[2:0] at all other times.
REQ-015 PC is 8-bit and wraps 8'hFF -> 8'h00; an instruction may straddle the wrap.
REQ-016 start while busy = 1 is ignored; start held high in HALT restarts immediately.
REQ-017 The accumulator width is 8 bits; no carry is retained.
REQ-018 Exactly one memory transaction is outstanding at any time.

Reset
REQ-019 When rst_n = 0 at a rising edge, the next state is:
- State = IDLE; PC = RESET_PC.
- AC, DR, IR, OPA = 0.
- mem_req, mem_we, alu_activate, busy, halted = 0.
- mem_addr, mem_wdata, alu_mode = 0.
REQ-020 Reset mid-transaction abandons the request; mem_req is 0 in the cycle after reset is sampled; a late mem_ack is ignored.

Verification
REQ-021 Load then add:
- Stimulus: mem = {04,10,00,11,07}, mem[10] = 05, mem[11] = 03, zero-wait ack, start.
- Response: AC = 05, then AC = 08; halted = 1 with pc = 05.
REQ-022 Store:
- Stimulus: program load 3C, store to 20, halt.
- Response: exactly one write, addr = 20, wdata = 3C, mem_we = 1 held until ack.
REQ-023 Wait states:
- Stimulus: mem_ack delayed 3 cycles on every access.
- Response: mem_addr and mem_req stable across the wait; final AC identical to the zero-wait run.
REQ-024 Negate and wrap:
- Stimulus: AC = 01; negate opcode at FE, operand at FF; next opcode at 00.
- Response: AC = FF; pc reads 00 after the operand fetch; no READ_DR access.
REQ-025 Reset mid-read:
- Stimulus: rst_n = 0 while mem_req = 1, ack pending.
- Response: next cycle mem_req = 0, busy = 0, AC = 00; start then re-executes from RESET_PC.
REQ-026 Start during busy:
- Stimulus: start pulses during EXEC.
- Response: no PC reload; the instruction stream continues unchanged.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: two-byte-instruction sequencer driving an external ALU and a
// single-outstanding request/acknowledge memory port. Every memory access is
// a separate request: the request drops in the cycle after the acknowledge and
// the next access is issued one cycle later, so acknowledges never overlap.
module alu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [2:0] alu_mode,
  output logic       alu_activate,
  input  logic [7:0] alu_result,
  output logic [7:0] ac,
  output logic [7:0] pc,
  output logic       busy,
  output logic       halted
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH_OP  = 3'd1;
  localparam logic [2:0] FETCH_ADR = 3'd2;
  localparam logic [2:0] READ_DR   = 3'd3;
  localparam logic [2:0] EXEC      = 3'd4;
  localparam logic [2:0] WB        = 3'd5;
  localparam logic [2:0] STORE     = 3'd6;
  localparam logic [2:0] HALT      = 3'd7;

  localparam logic [2:0] MODE_STORE  = 3'b101;
  localparam logic [2:0] MODE_NEGATE = 3'b110;
  localparam logic [2:0] MODE_HALT   = 3'b111;

  logic [2:0] state;
  logic [2:0] ir;
  logic [7:0] opa;
  logic [7:0] dr;

  // Status and ALU strobes decode directly from the state; only the mode bits
  // of the opcode are kept, the upper opcode bits carry no meaning.
  assign alu_mode     = ir;
  assign alu_activate = (state == EXEC);
  assign busy         = (state != IDLE) && (state != HALT);
  assign halted       = (state == HALT);

  // Writes carry the accumulator; AC cannot change during STORE, so the data
  // is stable for the whole request. Outside writes the port shows DR.
  assign mem_wdata = mem_we ? ac : dr;

  // Main sequencer: each memory state first raises a request with its
  // address, then waits for the acknowledge, captures data and moves on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ac       <= 8'h00;
      dr       <= 8'h00;
      ir       <= 3'b000;
      opa      <= 8'h00;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 8'h00;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state <= FETCH_OP;
            pc    <= RESET_PC;
          end
        end

        FETCH_OP: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            ir      <= mem_rdata[2:0];
            pc      <= pc + 8'd1;
            state   <= (mem_rdata[2:0] == MODE_HALT) ? HALT : FETCH_ADR;
          end
        end

        FETCH_ADR: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            opa     <= mem_rdata;
            pc      <= pc + 8'd1;
            if (ir == MODE_STORE)
              state <= STORE;
            else if (ir == MODE_NEGATE)
              state <= EXEC;
            else
              state <= READ_DR;
          end
        end

        READ_DR: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= opa;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            dr      <= mem_rdata;
            state   <= EXEC;
          end
        end

        EXEC: begin
          state <= WB;
        end

        WB: begin
          ac    <= alu_result;
          state <= FETCH_OP;
        end

        STORE: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= opa;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= FETCH_OP;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed programs with hand-computed results, a memory
// responder with programmable wait states and a small external ALU model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [2:0] alu_mode;
  logic       alu_activate;
  logic [7:0] alu_result;
  logic [7:0] ac;
  logic [7:0] pc;
  logic       busy;
  logic       halted;

  logic [7:0] mem [256];
  int         waitCycles;
  int         waitCnt;
  int         readCount;
  int         writeCount;
  int         stableErrors;
  logic [7:0] lastRead;
  logic [7:0] lastWrAddr;
  logic [7:0] lastWrData;
  logic [7:0] holdAddr;
  logic       holdWe;
  logic [7:0] holdData;
  logic       injectAck;
  logic [7:0] acLog [$];
  logic [7:0] prevAc;
  int         compareCount;
  int         mismatchCount;

  alu_sequencer #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_mode(alu_mode), .alu_activate(alu_activate), .alu_result(alu_result),
    .ac(ac), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory responder: acknowledges each request after waitCycles cycles with a
  // one-cycle pulse and flags any change of address/direction/data mid-wait.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (injectAck) begin
      mem_ack   = 1'b1;
      injectAck = 1'b0;
    end else if (mem_req) begin
      if (waitCnt == 0) begin
        holdAddr = mem_addr;
        holdWe   = mem_we;
        holdData = mem_wdata;
      end else if (mem_addr != holdAddr || mem_we != holdWe ||
                   (mem_we && mem_wdata != holdData)) begin
        stableErrors++;
      end
      if (waitCnt >= waitCycles) begin
        mem_ack = 1'b1;
        waitCnt = 0;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          writeCount++;
          lastWrAddr = mem_addr;
          lastWrData = mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr];
          readCount++;
          lastRead = mem_rdata;
        end
      end else begin
        waitCnt++;
      end
    end else begin
      if (waitCnt != 0) stableErrors++;
      waitCnt = 0;
    end
  end

  // External ALU: result appears the cycle after the strobe; the memory
  // operand is the most recent read, which is the READ_DR access.
  always @(posedge clk) begin
    if (alu_activate) begin
      case (alu_mode)
        3'b000:  alu_result <= ac + lastRead;
        3'b001:  alu_result <= ac << 1;
        3'b010:  alu_result <= ~(ac ^ lastRead);
        3'b011:  alu_result <= ac >> 1;
        3'b100:  alu_result <= lastRead;
        3'b110:  alu_result <= 8'h00 - ac;
        default: alu_result <= ac;
      endcase
    end
  end

  // Accumulator history, one entry per change.
  always @(negedge clk) begin
    if (ac !== prevAc) begin
      acLog.push_back(ac);
      prevAc = ac;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearLog();
    acLog.delete();
    prevAc = ac;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clearLog();
  endtask

  task automatic applyStimulus(input int waitN);
    waitCycles   = waitN;
    readCount    = 0;
    writeCount   = 0;
    stableErrors = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitHalt(input int budget, input string tag);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic loadProg1();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h04; mem[1] = 8'h10; mem[2] = 8'h00; mem[3] = 8'h11; mem[4] = 8'h07;
    mem[8'h10] = 8'h05;
    mem[8'h11] = 8'h03;
  endtask

  task automatic checkLog2(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] a0;
    logic [7:0] a1;
    a0 = (acLog.size() > 0) ? acLog[0] : 8'h00;
    a1 = (acLog.size() > 1) ? acLog[1] : 8'h00;
    checkOutput({tag, "_log_size"}, acLog.size(), 32'd2);
    checkOutput({tag, "_ac_first"}, {24'd0, a0}, {24'd0, e0});
    checkOutput({tag, "_ac_second"}, {24'd0, a1}, {24'd0, e1});
  endtask

  initial begin
    int n;
    int execPulses;
    compareCount  = 0;
    mismatchCount = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    alu_result = 8'h00;
    injectAck = 1'b0;
    waitCycles = 0;
    waitCnt = 0;
    lastRead = 8'h00;
    prevAc = 8'h00;
    loadProg1();

    // Reset state
    doReset();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_pc", {24'd0, pc}, 32'h00);
    checkOutput("rst_ac", {24'd0, ac}, 32'h00);
    checkOutput("rst_mem_addr", {24'd0, mem_addr}, 32'h00);
    checkOutput("rst_alu_mode", {29'd0, alu_mode}, 32'd0);
    checkOutput("rst_alu_act", {31'd0, alu_activate}, 32'd0);

    // Load then add, zero wait
    applyStimulus(0);
    waitHalt(300, "prog1");
    checkOutput("prog1_ac", {24'd0, ac}, 32'h08);
    checkOutput("prog1_pc", {24'd0, pc}, 32'h05);
    checkOutput("prog1_reads", readCount, 32'd7);
    checkOutput("prog1_writes", writeCount, 32'd0);
    checkLog2("prog1", 8'h05, 8'h08);

    // Start held in HALT restarts at once
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("halt_restart_busy", {31'd0, busy}, 32'd1);
    checkOutput("halt_restart_pc", {24'd0, pc}, 32'h00);

    // Store with wait states
    doReset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h04; mem[1] = 8'h30; mem[2] = 8'h05; mem[3] = 8'h20; mem[4] = 8'h07;
    mem[8'h30] = 8'h3C;
    applyStimulus(2);
    waitHalt(400, "store");
    checkOutput("store_writes", writeCount, 32'd1);
    checkOutput("store_addr", {24'd0, lastWrAddr}, 32'h20);
    checkOutput("store_wdata", {24'd0, lastWrData}, 32'h3C);
    checkOutput("store_mem", {24'd0, mem[8'h20]}, 32'h3C);
    checkOutput("store_ac", {24'd0, ac}, 32'h3C);
    checkOutput("store_stable", stableErrors, 32'd0);

    // Three wait cycles on every access
    doReset();
    loadProg1();
    applyStimulus(3);
    waitHalt(600, "wait3");
    checkOutput("wait3_ac", {24'd0, ac}, 32'h08);
    checkOutput("wait3_pc", {24'd0, pc}, 32'h05);
    checkOutput("wait3_stable", stableErrors, 32'd0);
    checkOutput("wait3_reads", readCount, 32'd7);

    // Negate straddling the PC wrap; AC=01 loaded repeatedly from FF
    doReset();
    for (int i = 0; i < 127; i++) begin
      mem[2*i]   = 8'h04;
      mem[2*i+1] = 8'hFF;
    end
    mem[8'hFE] = 8'h06;
    mem[8'hFF] = 8'h01;
    applyStimulus(0);
    n = 0;
    while (ac !== 8'hFF && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wrap_ac", {24'd0, ac}, 32'hFF);
    checkOutput("wrap_pc", {24'd0, pc}, 32'h00);
    checkOutput("wrap_reads", readCount, 32'd383);

    // Reset in the middle of a read
    doReset();
    loadProg1();
    applyStimulus(0);
    waitHalt(300, "prerst");
    waitCycles = 20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_req_before", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_ac", {24'd0, ac}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    injectAck = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("late_ack_busy", {31'd0, busy}, 32'd0);
    checkOutput("late_ack_pc", {24'd0, pc}, 32'h00);
    clearLog();
    applyStimulus(0);
    waitHalt(300, "rerun");
    checkOutput("rerun_ac", {24'd0, ac}, 32'h08);
    checkOutput("rerun_pc", {24'd0, pc}, 32'h05);
    checkOutput("rerun_reads", readCount, 32'd7);

    // Start pulses during EXEC must be ignored
    doReset();
    loadProg1();
    applyStimulus(0);
    n = 0;
    execPulses = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      start = alu_activate;
      if (alu_activate) execPulses++;
      n++;
    end
    start = 1'b0;
    checkOutput("busy_start_halted", {31'd0, halted}, 32'd1);
    checkOutput("busy_start_pulses", execPulses, 32'd2);
    checkOutput("busy_start_ac", {24'd0, ac}, 32'h08);
    checkOutput("busy_start_pc", {24'd0, pc}, 32'h05);
    checkOutput("busy_start_reads", readCount, 32'd7);
    checkLog2("busy_start", 8'h05, 8'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
